// File: rtl/ula_serial_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: operation codes and FSM state encodings.
package ula_serial_seq_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_SOMA = 2'b00;
    localparam op_t OP_SUB  = 2'b01;
    localparam op_t OP_AND  = 2'b10;
    localparam op_t OP_OR   = 2'b11;

    localparam logic [1:0] ST_OCIOSO  = 2'b00;
    localparam logic [1:0] ST_DESLOCA = 2'b01;
    localparam logic [1:0] ST_CONCLUI = 2'b10;

endpackage

// File: rtl/ula_serial_seq_bit_carry.sv
// Combinational 1-bit ALU slice: sum/difference bit with carry chain, or a bitwise and/or.
module ula_bit_carry
    import ula_serial_seq_pkg::*;
(
    input  logic       a,
    input  logic       b,
    input  logic       cin,
    input  logic [1:0] seletor,
    output logic       s,
    output logic       cout
);

    logic bEff;

    // Subtraction is a + ~b + 1; the +1 comes from the carry register preset at acceptance.
    always_comb begin
        bEff = (seletor == OP_SUB) ? ~b : b;
        s    = 1'b0;
        cout = 1'b0;
        case (seletor)
            OP_SOMA, OP_SUB: begin
                s    = a ^ bEff ^ cin;
                cout = (a & bEff) | (cin & (a ^ bEff));
            end
            OP_AND:  s = a & b;
            OP_OR:   s = a | b;
            default: s = 1'b0;
        endcase
    end

endmodule

// File: rtl/ula_serial_seq.sv
// Bit-serial sequencer feeding LARGURA-bit operands LSB-first through a 1-bit ALU slice.
// Optional flag logic (zero/overflow) enabled by defining ULA_SERIAL_FLAGS_EN.
module ula_serial_seq
    import ula_serial_seq_pkg::*;
#(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inicio,
    output logic               pronto,
    input  logic [LARGURA-1:0] operando_a,
    input  logic [LARGURA-1:0] operando_b,
    input  logic [1:0]         seletor,
    output logic [LARGURA-1:0] resultado,
    output logic               valido,
    output logic               carry_out,
    output logic               zero,
    output logic               overflow
);

    localparam int CW = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [CW-1:0] LAST = CW'(LARGURA - 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LARGURA-1:0] opA_q, opA_d;
    logic [LARGURA-1:0] opB_q, opB_d;
    logic [1:0]         sel_q, sel_d;
    logic               carry_q, carry_d;
    logic [LARGURA-1:0] shift_q, shift_d;
    logic [LARGURA-1:0] res_q, res_d;
    logic               cOut_q, cOut_d;
    logic               sliceS, sliceCout;
    logic [LARGURA-1:0] resNext;

    ula_bit_carry u_slice (
        .a       (opA_q[0]),
        .b       (opB_q[0]),
        .cin     (carry_q),
        .seletor (sel_q),
        .s       (sliceS),
        .cout    (sliceCout)
    );

    // The bit computed on the final edge is the MSB, so the full result is the shifted value.
    assign resNext = {sliceS, shift_q[LARGURA-1:1]};

`ifdef ULA_SERIAL_FLAGS_EN
    logic zero_q, zero_d;
    logic ovf_q, ovf_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opA_d   = opA_q;
        opB_d   = opB_q;
        sel_d   = sel_q;
        carry_d = carry_q;
        shift_d = shift_q;
        res_d   = res_q;
        cOut_d  = cOut_q;
`ifdef ULA_SERIAL_FLAGS_EN
        zero_d  = zero_q;
        ovf_d   = ovf_q;
`endif
        case (state_q)
            ST_OCIOSO: begin
                if (inicio) begin
                    opA_d   = operando_a;
                    opB_d   = operando_b;
                    sel_d   = seletor;
                    carry_d = (seletor == OP_SUB);
                    cnt_d   = '0;
                    shift_d = '0;
                    state_d = ST_DESLOCA;
                end
            end
            ST_DESLOCA: begin
                opA_d   = opA_q >> 1;
                opB_d   = opB_q >> 1;
                carry_d = sliceCout;
                shift_d = resNext;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    res_d   = resNext;
                    cOut_d  = sliceCout;
                    cnt_d   = '0;
                    state_d = ST_CONCLUI;
`ifdef ULA_SERIAL_FLAGS_EN
                    // carry_q is the carry into the MSB while the slice works on the MSB.
                    zero_d  = (resNext == '0);
                    ovf_d   = ((sel_q == OP_SOMA) || (sel_q == OP_SUB)) ? (carry_q ^ sliceCout) : 1'b0;
`endif
                end
            end
            ST_CONCLUI: state_d = ST_OCIOSO;
            default:    state_d = ST_OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_OCIOSO;
            cnt_q   <= '0;
            opA_q   <= '0;
            opB_q   <= '0;
            sel_q   <= OP_SOMA;
            carry_q <= 1'b0;
            shift_q <= '0;
            res_q   <= '0;
            cOut_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opA_q   <= opA_d;
            opB_q   <= opB_d;
            sel_q   <= sel_d;
            carry_q <= carry_d;
            shift_q <= shift_d;
            res_q   <= res_d;
            cOut_q  <= cOut_d;
        end
    end

`ifdef ULA_SERIAL_FLAGS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
        end
    end

    assign zero     = zero_q;
    assign overflow = ovf_q;
`else
    assign zero     = 1'b0;
    assign overflow = 1'b0;
`endif

    assign pronto    = (state_q == ST_OCIOSO);
    assign valido    = (state_q == ST_CONCLUI);
    assign resultado = res_q;
    assign carry_out = cOut_q;

endmodule

// File: tb/tb_ula_serial_seq.sv
// Self-checking bench for ula_serial_seq: arithmetic reference model plus directed vectors.
// Flag expectations follow ULA_SERIAL_FLAGS_EN as defined for the build.
module tb_ula_serial_seq;
    import ula_serial_seq_pkg::*;

    localparam int W = 8;
`ifdef ULA_SERIAL_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         v;
    } opResult_t;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         inicio = 1'b0;
    logic [W-1:0] operando_a = '0;
    logic [W-1:0] operando_b = '0;
    logic [1:0]   seletor = OP_SOMA;
    logic         pronto, valido, carry_out, zero, overflow;
    logic [W-1:0] resultado;

    int nChecks = 0;
    int nFails = 0;

    ula_serial_seq #(.LARGURA(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .inicio     (inicio),
        .pronto     (pronto),
        .operando_a (operando_a),
        .operando_b (operando_b),
        .seletor    (seletor),
        .resultado  (resultado),
        .valido     (valido),
        .carry_out  (carry_out),
        .zero       (zero),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Reference result straight from integer arithmetic on the whole words.
    function automatic opResult_t modelOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] sel);
        opResult_t r;
        logic [W:0] wide;
        r = '0;
        case (sel)
            OP_SOMA: begin
                wide  = {1'b0, a} + {1'b0, b};
                r.res = wide[W-1:0];
                r.c   = wide[W];
                r.v   = (a[W-1] == b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} - {1'b0, b};
                r.res = wide[W-1:0];
                r.c   = (a >= b);
                r.v   = (a[W-1] != b[W-1]) && (r.res[W-1] != a[W-1]);
            end
            OP_AND: r.res = a & b;
            default: r.res = a | b;
        endcase
        r.z = FLAGS ? (r.res == '0) : 1'b0;
        r.v = FLAGS ? r.v : 1'b0;
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: 0 = idle, 1..W = shifting, W+1 = completion cycle.
    int        mPhase = 0;
    opResult_t mPending = '0;
    opResult_t mOut = '0;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mPhase = 0;
            mOut   = '0;
        end else if (mPhase == 0) begin
            if (inicio) begin
                mPending = modelOp(operando_a, operando_b, seletor);
                mPhase   = 1;
            end
        end else if (mPhase == W + 1) begin
            mPhase = 0;
        end else begin
            mPhase = mPhase + 1;
            if (mPhase == W + 1) mOut = mPending;
        end
    end

    always @(negedge clock) begin
        checkOutput("cyc pronto", pronto, (mPhase == 0));
        checkOutput("cyc valido", valido, (mPhase == W + 1));
        checkOutput("cyc resultado", resultado, mOut.res);
        checkOutput("cyc carry_out", carry_out, mOut.c);
        checkOutput("cyc zero", zero, mOut.z);
        checkOutput("cyc overflow", overflow, mOut.v);
    end

    task automatic applyStimulus(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [1:0] sel, input logic [W-1:0] expRes,
                                 input logic expC, input logic expZ, input logic expV);
        int n;
        @(negedge clock);
        operando_a = a;
        operando_b = b;
        seletor    = sel;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        inicio     = 1'b0;
        operando_a = ~a;
        operando_b = ~b;
        seletor    = ~sel;
        checkOutput({name, " busy"}, pronto, 1'b0);
        n = 0;
        while (!valido && n < 20) begin
            @(posedge clock);
            #1;
            n++;
        end
        checkOutput({name, " latency"}, n, 8);
        checkOutput({name, " resultado"}, resultado, expRes);
        checkOutput({name, " carry_out"}, carry_out, expC);
        checkOutput({name, " zero"}, zero, expZ);
        checkOutput({name, " overflow"}, overflow, expV);
        @(posedge clock);
        #1;
        checkOutput({name, " pronto again"}, pronto, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        opResult_t pin;
        int pulses;

        pin = modelOp(8'hC8, 8'h64, OP_SOMA);
        checkOutput("model soma res", pin.res, 8'h2C);
        checkOutput("model soma c", pin.c, 1'b1);
        pin = modelOp(8'h05, 8'h07, OP_SUB);
        checkOutput("model sub res", pin.res, 8'hFE);
        checkOutput("model sub c", pin.c, 1'b0);
        pin = modelOp(8'h80, 8'h01, OP_SUB);
        checkOutput("model sub ovf", pin.v, FLAGS);

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset pronto", pronto, 1'b1);
        checkOutput("reset valido", valido, 1'b0);
        checkOutput("reset resultado", resultado, 8'h00);
        @(negedge clock);
        #1;
        reset = 1'b0;

        applyStimulus("soma C8+64", 8'hC8, 8'h64, OP_SOMA, 8'h2C, 1'b1, 1'b0, 1'b0);

        // Abort an operation at bit 3 with an asynchronous reset.
        @(negedge clock);
        operando_a = 8'h12;
        operando_b = 8'h34;
        seletor    = OP_SOMA;
        inicio     = 1'b1;
        @(posedge clock);
        #1;
        inicio = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("midreset pronto", pronto, 1'b1);
        checkOutput("midreset valido", valido, 1'b0);
        checkOutput("midreset resultado", resultado, 8'h00);
        checkOutput("midreset carry_out", carry_out, 1'b0);
        checkOutput("midreset flags", {zero, overflow}, 2'b00);
        @(negedge clock);
        #1;
        reset  = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (valido) pulses++;
        end
        checkOutput("midreset no valido", pulses, 0);

        applyStimulus("sub 05-07", 8'h05, 8'h07, OP_SUB, 8'hFE, 1'b0, 1'b0, 1'b0);
        applyStimulus("sub 80-01", 8'h80, 8'h01, OP_SUB, 8'h7F, 1'b1, 1'b0, FLAGS);
        applyStimulus("sub 3A-3A", 8'h3A, 8'h3A, OP_SUB, 8'h00, 1'b1, FLAGS, 1'b0);
        applyStimulus("and F0,3C", 8'hF0, 8'h3C, OP_AND, 8'h30, 1'b0, 1'b0, 1'b0);
        applyStimulus("or F0,3C", 8'hF0, 8'h3C, OP_OR, 8'hFC, 1'b0, 1'b0, 1'b0);
        applyStimulus("soma 7F+01", 8'h7F, 8'h01, OP_SOMA, 8'h80, 1'b0, 1'b0, FLAGS);

        // inicio held high with operands changing every cycle: three back-to-back operations.
        @(negedge clock);
        inicio = 1'b1;
        pulses = 0;
        for (int k = 0; k < 30; k++) begin
            operando_a = W'($urandom);
            operando_b = W'($urandom);
            seletor    = 2'($urandom_range(0, 3));
            @(posedge clock);
            #1;
            if (valido) pulses++;
            @(negedge clock);
        end
        inicio = 1'b0;
        checkOutput("burst valido pulses", pulses, 3);
        repeat (12) @(posedge clock);
        #1;
        checkOutput("burst idle", pronto, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
